servile_timer: RTL and testbench
================================

// Module: servile_timer
// PURPOSE
// - Memory-mapped RISC-V machine timer (mtime/mtimecmp) on the servile extension Wishbone bus.
// - Consumes o_wb_ext_* from servile; produces i_timer_irq for the SERV core.
// - Adds a programmable prescaler and a coherent 64-bit mtime read via a latched high-word shadow.
// PARAMETERS
// - RESET_CMP   64'hFFFF_FFFF_FFFF_FFFF  reset value of mtimecmp; the default keeps the IRQ quiet after reset
// - PRESCALE_W  16                       width of the prescaler divider register and counter
// - RESET_DIV   0                        reset divider value; 0 gives one tick per clock
// PORTS
// - i_clk         in   1   clock
// - i_rst_n       in   1   asynchronous reset, active low
// - i_wb_adr      in   3   word address = ext bus adr[4:2]
// - i_wb_dat      in   32  write data
// - i_wb_sel      in   4   byte enables
// - i_wb_we       in   1   write strobe qualifier
// - i_wb_stb      in   1   cycle/strobe; held by master until ack
// - o_wb_rdt      out  32  read data, valid with ack
// - o_wb_ack      out  1   single-cycle acknowledge
// - o_timer_irq   out  1   level interrupt to core i_timer_irq
// BEHAVIOUR
// - Interface: one clock (i_clk); reset i_rst_n is asynchronous and active low.
// - Register map (word index):
//   0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL{[1]irq_en,[0]en}, 5 DIV[PRESCALE_W-1:0].
//   Indices 6 and 7 are unmapped: they ack, read 0 and ignore writes.
// - Reset values:
//   - mtime = 0, mtimecmp = RESET_CMP, CTRL = 2'b11, DIV = RESET_DIV, prescaler count = 0, shadow = 0.
//   - o_wb_ack = 0, o_wb_rdt = 0, o_timer_irq = 0.
// - Handshake:
//   - o_wb_ack <= i_wb_stb & ~o_wb_ack.
//   - Exactly one ack per access, 1 cycle after stb; no back-to-back ack.
//   - Writes take effect on the ack edge.
//   - o_wb_rdt is registered and updates on that same edge; it is 0 when there is no ack.
// - Byte lanes: writes honour i_wb_sel per byte; unselected bytes keep their value. DIV/CTRL bits above the field width are ignored and read 0.
// - Prescaler:
//   - While en=1, cnt increments each clock.
//   - tick = (cnt == DIV); on tick, cnt <= 0.
//   - While en=0, cnt holds and no tick occurs.
//   - A write to DIV clears cnt.
// - mtime: on tick, mtime <= mtime + 1 as a 64-bit add. It wraps from all ones to 0 with no flag.
// - Write vs tick collision:
//   - A write to MTIME_LO or MTIME_HI in the same cycle as a tick wins; that increment is lost.
//   - The written half takes the new bytes; the other half holds its old value (no carry).
// - Shadow:
//   - Reading MTIME_LO returns mtime[31:0] and latches mtime[63:32] into the shadow on the same edge.
//   - Reading MTIME_HI returns the shadow, not the live high word.
//   - MTIMECMP reads are live.
// - IRQ:
//   - o_timer_irq <= irq_en & (mtime >= mtimecmp), unsigned 64-bit compare, registered with 1-cycle lag.
//   - Writing mtimecmp above mtime deasserts the IRQ on the 2nd edge after ack.
//   - irq_en=0 forces the IRQ low on the next edge.
// - Reset mid-access: all state returns to reset values immediately. A pending stb is acked 1 cycle after reset release if still held.
// STRUCTURE
// - servile_timer_defs.vh: localparams for the register indices, CTRL bit positions and reset values.
// - Sub-module servile_timer_presc: DIV register, count, en gating, tick output.
// - The top holds the WB decode, mtime, mtimecmp, shadow and IRQ compare.
// TESTING
// 1. Reset, then read every register.
//    -> MTIME=0, MTIMECMP=all ones, CTRL=3, DIV=0, irq=0.
//    -> Each access gets exactly one ack, 1 cycle after stb.
// 2. DIV=3, en=1; run 40 clocks.
//    -> mtime advances by exactly 10.
//    -> Write DIV=0 -> +1 per clock thereafter.
// 3. Write MTIME_LO=FFFF_FFFF, MTIME_HI=0, DIV=0; run 2 ticks.
//    -> Read LO=0000_0001, then HI=1.
//    -> Shadow test: read LO, run until hi changes, then read HI -> still the latched value.
// 4. MTIMECMP={0,100}, mtime=0, DIV=0.
//    -> irq rises on the edge after mtime first reaches 100.
//    -> Write CMP_HI=1 -> irq falls 2 edges after ack.
//    -> irq_en=0 -> irq stays low.
// 5. Write MTIME_LO=0x1234_5678 with sel=4'b0011 on a tick cycle.
//    -> LO=old[31:16]_5678 with no increment that cycle; HI unchanged.
// 6. Assert i_rst_n low mid-stb with mtime=500.
//    -> All outputs 0, mtime=0; ack 1 cycle after release while stb is held.
//    -> Access to index 7 -> ack with rdt=0.

Source files
------------

// File: rtl/servile_timer_pkg.sv
// Shared definitions for the servile machine timer.
// - Word indices of the register map, CTRL bit positions, CTRL reset value.
// - merge_bytes: byte-lane write merge used by every writable register.
package servile_timer_pkg;

   localparam logic [2:0] ADR_MTIME_LO    = 3'd0;
   localparam logic [2:0] ADR_MTIME_HI    = 3'd1;
   localparam logic [2:0] ADR_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] ADR_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] ADR_CTRL        = 3'd4;
   localparam logic [2:0] ADR_DIV         = 3'd5;

   localparam int         CTRL_EN         = 0;
   localparam int         CTRL_IRQ_EN     = 1;
   localparam logic [1:0] CTRL_RESET      = 2'b11;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/servile_timer_if.sv
// Servile extension Wishbone slave bus as seen by the timer.
// - adr/dat/sel/we/stb : master -> timer (adr is the word index, ext adr[4:2])
// - rdt/ack            : timer -> master, rdt valid only with ack
interface servile_timer_if;
   logic [2:0]  adr;
   logic [31:0] dat;
   logic [3:0]  sel;
   logic        we;
   logic        stb;
   logic [31:0] rdt;
   logic        ack;

   modport master (output adr, dat, sel, we, stb, input  rdt, ack);
   modport slave  (input  adr, dat, sel, we, stb, output rdt, ack);
endinterface

// File: rtl/servile_timer_presc.sv
// Programmable prescaler for the machine timer.
// - i_clk, i_rst_n : clock, async active-low reset
// - i_en           : count enable (CTRL.en)
// - i_div_we       : write strobe for the DIV register (also clears the count)
// - i_sel, i_wdat  : byte enables and write data for DIV
// - o_div          : current DIV value
// - o_tick         : one-clock pulse every DIV+1 enabled clocks
module servile_timer_presc
   import servile_timer_pkg::*;
#(
   parameter int PRESCALE_W = 16,
   parameter int RESET_DIV  = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic                  i_div_we,
   input  logic [3:0]            i_sel,
   input  logic [31:0]           i_wdat,
   output logic [PRESCALE_W-1:0] o_div,
   output logic                  o_tick
);

   logic [PRESCALE_W-1:0] div_q;
   logic [PRESCALE_W-1:0] cnt_q;

   assign o_div  = div_q;
   assign o_tick = i_en & (cnt_q == div_q);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_q <= PRESCALE_W'(RESET_DIV);
         cnt_q <= '0;
      end else if (i_div_we) begin
         // bits of the written word above PRESCALE_W are dropped
         div_q <= PRESCALE_W'(merge_bytes(32'(div_q), i_wdat, i_sel));
         cnt_q <= '0;
      end else if (i_en) begin
         cnt_q <= o_tick ? '0 : cnt_q + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/servile_timer.sv
// RISC-V machine timer (mtime/mtimecmp) on the servile extension bus.
// - i_clk, i_rst_n : clock, async active-low reset
// - wb             : Wishbone slave; single-cycle ack one clock after stb
// - o_timer_irq    : level interrupt, irq_en & (mtime >= mtimecmp), registered
// Reading MTIME_LO latches mtime[63:32] into a shadow that MTIME_HI returns,
// giving a coherent 64-bit read as LO then HI.
module servile_timer
   import servile_timer_pkg::*;
#(
   parameter logic [63:0] RESET_CMP  = 64'hFFFF_FFFF_FFFF_FFFF,
   parameter int          PRESCALE_W = 16,
   parameter int          RESET_DIV  = 0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   servile_timer_if.slave   wb,
   output logic             o_timer_irq
);

   logic [63:0]           mtime;
   logic [63:0]           mtimecmp;
   logic [1:0]            ctrl;
   logic [31:0]           shadow;
   logic [PRESCALE_W-1:0] div;
   logic                  tick;
   logic                  access;
   logic                  wr;
   logic                  rd;
   logic [31:0]           rd_mux;

   // the access is serviced on the edge that raises ack
   assign access = wb.stb & ~wb.ack;
   assign wr     = access &  wb.we;
   assign rd     = access & ~wb.we;

   servile_timer_presc #(
      .PRESCALE_W (PRESCALE_W),
      .RESET_DIV  (RESET_DIV)
   ) u_presc (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (ctrl[CTRL_EN]),
      .i_div_we (wr & (wb.adr == ADR_DIV)),
      .i_sel    (wb.sel),
      .i_wdat   (wb.dat),
      .o_div    (div),
      .o_tick   (tick)
   );

   always_comb begin
      rd_mux = '0;
      case (wb.adr)
         ADR_MTIME_LO:    rd_mux = mtime[31:0];
         ADR_MTIME_HI:    rd_mux = shadow;
         ADR_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
         ADR_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
         ADR_CTRL:        rd_mux = {30'd0, ctrl};
         ADR_DIV:         rd_mux = 32'(div);
         default:         rd_mux = '0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wb.ack      <= 1'b0;
         wb.rdt      <= '0;
         mtime       <= '0;
         mtimecmp    <= RESET_CMP;
         ctrl        <= CTRL_RESET;
         shadow      <= '0;
         o_timer_irq <= 1'b0;
      end else begin
         wb.ack      <= access;
         wb.rdt      <= access ? rd_mux : '0;
         o_timer_irq <= ctrl[CTRL_IRQ_EN] & (mtime >= mtimecmp);

         if (rd && (wb.adr == ADR_MTIME_LO))
            shadow <= mtime[63:32];

         // a software write to either half beats the tick; no carry across halves
         if (wr && (wb.adr == ADR_MTIME_LO))
            mtime[31:0]  <= merge_bytes(mtime[31:0], wb.dat, wb.sel);
         else if (wr && (wb.adr == ADR_MTIME_HI))
            mtime[63:32] <= merge_bytes(mtime[63:32], wb.dat, wb.sel);
         else if (tick)
            mtime <= mtime + 64'd1;

         if (wr && (wb.adr == ADR_MTIMECMP_LO))
            mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], wb.dat, wb.sel);
         if (wr && (wb.adr == ADR_MTIMECMP_HI))
            mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wb.dat, wb.sel);
         if (wr && (wb.adr == ADR_CTRL))
            ctrl <= 2'(merge_bytes({30'd0, ctrl}, wb.dat, wb.sel));
      end
   end

endmodule

// File: tb/tb_servile_timer.sv
// Bench for servile_timer: reference model compared every cycle, a vector
// table for the configuration registers, directed timing sequences, and a
// randomized traffic phase.
module tb_servile_timer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;

   servile_timer_if wb_if();
   logic irq;

   servile_timer dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .wb          (wb_if),
      .o_timer_irq (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0] m_mtime, m_cmp;
   logic [31:0] m_div, m_cnt, m_shadow, m_rdt;
   logic        m_en, m_irq_en, m_ack, m_irq;

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (o & ~mask) | (n & mask);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mtime = 0; m_cmp = '1; m_en = 1; m_irq_en = 1; m_div = 0; m_cnt = 0;
         m_shadow = 0; m_ack = 0; m_rdt = 0; m_irq = 0;
      end else begin
         logic        acc, tick;
         logic [63:0] n_mtime;
         logic [31:0] n_cnt, n_rdt, c;
         acc  = wb_if.stb && !m_ack;
         tick = m_en && (m_cnt == m_div);
         n_rdt = 0;
         if (acc) begin
            case (wb_if.adr)
               3'd0: n_rdt = m_mtime[31:0];
               3'd1: n_rdt = m_shadow;
               3'd2: n_rdt = m_cmp[31:0];
               3'd3: n_rdt = m_cmp[63:32];
               3'd4: n_rdt = {30'd0, m_irq_en, m_en};
               3'd5: n_rdt = m_div;
               default: n_rdt = 0;
            endcase
         end
         m_irq   = m_irq_en && (m_mtime >= m_cmp);
         n_mtime = tick ? m_mtime + 1 : m_mtime;
         n_cnt   = !m_en ? m_cnt : (tick ? 0 : m_cnt + 1);
         if (acc && !wb_if.we && wb_if.adr == 3'd0) m_shadow = m_mtime[63:32];
         if (acc && wb_if.we) begin
            case (wb_if.adr)
               3'd0: n_mtime = {m_mtime[63:32], bmerge(m_mtime[31:0], wb_if.dat, wb_if.sel)};
               3'd1: n_mtime = {bmerge(m_mtime[63:32], wb_if.dat, wb_if.sel), m_mtime[31:0]};
               3'd2: m_cmp[31:0]  = bmerge(m_cmp[31:0], wb_if.dat, wb_if.sel);
               3'd3: m_cmp[63:32] = bmerge(m_cmp[63:32], wb_if.dat, wb_if.sel);
               3'd4: begin
                  c = bmerge({30'd0, m_irq_en, m_en}, wb_if.dat, wb_if.sel);
                  m_en = c[0]; m_irq_en = c[1];
               end
               3'd5: begin
                  m_div = bmerge(m_div, wb_if.dat, wb_if.sel) & 32'h0000_FFFF;
                  n_cnt = 0;
               end
               default: ;
            endcase
         end
         m_mtime = n_mtime;
         m_cnt   = n_cnt;
         m_rdt   = n_rdt;
         m_ack   = acc;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("mon_ack", 64'(wb_if.ack), 64'(m_ack));
         chk("mon_rdt", 64'(wb_if.rdt), 64'(m_rdt));
         chk("mon_irq", 64'(irq), 64'(m_irq));
      end
   end

   // ---------------- bus driver ----------------
   // Call just after a negedge; returns at the negedge where ack was seen.
   task automatic bus(input logic [2:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r, output int ac,
                      output int lat);
      bit got = 0;
      wb_if.adr = a; wb_if.we = w; wb_if.dat = d; wb_if.sel = s; wb_if.stb = 1'b1;
      r = 0; ac = 0; lat = 0;
      for (int i = 1; i <= 8 && !got; i++) begin
         @(negedge clk);
         if (wb_if.ack) begin
            got = 1; r = wb_if.rdt; ac = cyc; lat = i;
         end
      end
      if (!got) chk("ack_timeout", 64'(0), 64'(1));
      wb_if.stb = 1'b0; wb_if.we = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      logic [31:0] r; int ac, lat;
      bus(a, 1'b1, d, 4'hF, r, ac, lat);
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] r);
      int ac, lat;
      bus(a, 1'b0, 32'd0, 4'hF, r, ac, lat);
   endtask

   typedef struct {
      logic [2:0]  adr;
      logic        we;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] r, v0, v1;
      int ac, lat, cz, ck;
      bit seen;

      wb_if.adr = 0; wb_if.dat = 0; wb_if.sel = 0; wb_if.we = 0; wb_if.stb = 0;

      vecs.push_back('{3'd2, 1'b0, 32'h0,        4'hF, 32'hFFFF_FFFF});
      vecs.push_back('{3'd3, 1'b0, 32'h0,        4'hF, 32'hFFFF_FFFF});
      vecs.push_back('{3'd4, 1'b0, 32'h0,        4'hF, 32'h0000_0003});
      vecs.push_back('{3'd5, 1'b0, 32'h0,        4'hF, 32'h0000_0000});
      vecs.push_back('{3'd6, 1'b0, 32'h0,        4'hF, 32'h0000_0000});
      vecs.push_back('{3'd7, 1'b0, 32'h0,        4'hF, 32'h0000_0000});
      vecs.push_back('{3'd2, 1'b1, 32'h1234_5678, 4'h5, 32'h0});
      vecs.push_back('{3'd2, 1'b0, 32'h0,        4'hF, 32'hFF34_FF78});
      vecs.push_back('{3'd3, 1'b1, 32'hA5A5_A5A5, 4'h8, 32'h0});
      vecs.push_back('{3'd3, 1'b0, 32'h0,        4'hF, 32'hA5FF_FFFF});
      vecs.push_back('{3'd5, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0});
      vecs.push_back('{3'd5, 1'b0, 32'h0,        4'hF, 32'h0000_BEEF});
      vecs.push_back('{3'd5, 1'b1, 32'h0000_1200, 4'h2, 32'h0});
      vecs.push_back('{3'd5, 1'b0, 32'h0,        4'hF, 32'h0000_12EF});
      vecs.push_back('{3'd4, 1'b1, 32'hFFFF_FFFE, 4'h1, 32'h0});
      vecs.push_back('{3'd4, 1'b0, 32'h0,        4'hF, 32'h0000_0002});
      vecs.push_back('{3'd4, 1'b1, 32'h0000_0003, 4'hE, 32'h0});
      vecs.push_back('{3'd4, 1'b0, 32'h0,        4'hF, 32'h0000_0002});
      vecs.push_back('{3'd6, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0});
      vecs.push_back('{3'd6, 1'b0, 32'h0,        4'hF, 32'h0000_0000});
      vecs.push_back('{3'd7, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0});
      vecs.push_back('{3'd7, 1'b0, 32'h0,        4'hF, 32'h0000_0000});
      vecs.push_back('{3'd5, 1'b1, 32'h0,        4'hF, 32'h0});
      vecs.push_back('{3'd4, 1'b1, 32'h3,        4'hF, 32'h0});
      vecs.push_back('{3'd5, 1'b0, 32'h0,        4'hF, 32'h0000_0000});
      vecs.push_back('{3'd4, 1'b0, 32'h0,        4'hF, 32'h0000_0003});

      // ---- 1: reset state and reads of every register ----
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_ack", 64'(wb_if.ack), 64'd0);
      chk("rst_rdt", 64'(wb_if.rdt), 64'd0);
      chk("rst_irq", 64'(irq), 64'd0);
      #2 rst_n = 1'b1;
      bus(3'd0, 1'b0, 0, 4'hF, r, ac, lat);
      chk("t1_mtime_lo", 64'(r), 64'd0);
      chk("t1_lat", 64'(lat), 64'd1);
      @(negedge clk);
      bus(3'd1, 1'b0, 0, 4'hF, r, ac, lat);
      chk("t1_mtime_hi", 64'(r), 64'd0);
      chk("t1_lat_hi", 64'(lat), 64'd1);
      @(negedge clk);
      chk("t1_irq", 64'(irq), 64'd0);

      foreach (vecs[i]) begin
         @(negedge clk);
         bus(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, r, ac, lat);
         chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd1);
         if (!vecs[i].we) chk($sformatf("vec%0d_rdt", i), 64'(r), 64'(vecs[i].exp));
      end

      // ---- 2: prescaler ----
      wr(3'd5, 32'd3);
      rd(3'd0, v0);
      repeat (39) @(negedge clk);
      rd(3'd0, v1);
      chk("t2_div3_40clk", 64'(v1 - v0), 64'd10);
      wr(3'd5, 32'd0);
      rd(3'd0, v0);
      repeat (19) @(negedge clk);
      rd(3'd0, v1);
      chk("t2_div0_20clk", 64'(v1 - v0), 64'd20);

      // ---- 3: carry into the high word and shadow ----
      wr(3'd1, 32'h0);
      wr(3'd0, 32'hFFFF_FFFF);
      repeat (2) @(negedge clk);
      rd(3'd0, r);
      chk("t3_lo_after_carry", 64'(r), 64'd1);
      rd(3'd1, r);
      chk("t3_hi_after_carry", 64'(r), 64'd1);
      wr(3'd0, 32'hFFFF_FFF0);
      rd(3'd0, r);
      chk("t3_lo_near_wrap", 64'(r), 64'hFFFF_FFF1);
      repeat (30) @(negedge clk);
      rd(3'd1, r);
      chk("t3_shadow_held", 64'(r), 64'd1);
      rd(3'd0, r);
      rd(3'd1, r);
      chk("t3_shadow_new", 64'(r), 64'd2);

      // ---- 4: interrupt ----
      wr(3'd3, 32'hFFFF_FFFF);
      wr(3'd1, 32'h0);
      bus(3'd0, 1'b1, 32'h0, 4'hF, r, cz, lat);
      wr(3'd2, 32'd100);
      wr(3'd3, 32'h0);
      chk("t4_irq_low_before", 64'(irq), 64'd0);
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (irq) seen = 1;
      end
      chk("t4_irq_rise_cycle", 64'(cyc - cz), 64'd101);
      bus(3'd3, 1'b1, 32'h1, 4'hF, r, ck, lat);
      chk("t4_irq_at_ack", 64'(irq), 64'd1);
      @(negedge clk);
      chk("t4_irq_fall", 64'(irq), 64'd0);
      wr(3'd3, 32'h0);
      repeat (2) @(negedge clk);
      chk("t4_irq_back", 64'(irq), 64'd1);
      wr(3'd4, 32'h1);
      chk("t4_irq_en_off_ack", 64'(irq), 64'd1);
      repeat (20) @(negedge clk);
      chk("t4_irq_en_off", 64'(irq), 64'd0);
      wr(3'd4, 32'h3);

      // ---- 5: write vs tick collision with partial byte enables ----
      wr(3'd1, 32'h77);
      wr(3'd0, 32'h00AB_0000);
      rd(3'd0, r);
      chk("t5_lo_before", 64'(r), 64'h00AB_0001);
      bus(3'd0, 1'b1, 32'h1234_5678, 4'h3, r, ac, lat);
      rd(3'd0, r);
      chk("t5_lo_merged", 64'(r), 64'h00AB_5679);
      rd(3'd1, r);
      chk("t5_hi_held", 64'(r), 64'h77);

      // ---- 6: reset in the middle of an access ----
      wr(3'd1, 32'h0);
      wr(3'd0, 32'd500);
      wb_if.adr = 3'd0; wb_if.we = 1'b0; wb_if.sel = 4'hF; wb_if.stb = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_ack", 64'(wb_if.ack), 64'd0);
      chk("t6_rst_rdt", 64'(wb_if.rdt), 64'd0);
      chk("t6_rst_irq", 64'(irq), 64'd0);
      repeat (3) @(negedge clk);
      chk("t6_hold_ack", 64'(wb_if.ack), 64'd0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("t6_ack_after_release", 64'(wb_if.ack), 64'd1);
      chk("t6_mtime_after_reset", 64'(wb_if.rdt), 64'd0);
      wb_if.stb = 1'b0;
      @(negedge clk);
      chk("t6_single_ack", 64'(wb_if.ack), 64'd0);
      wr(3'd7, 32'hFFFF_FFFF);
      rd(3'd7, r);
      chk("t6_idx7", 64'(r), 64'd0);
      rd(3'd2, r);
      chk("t6_cmp_reset", 64'(r), 64'hFFFF_FFFF);
      rd(3'd4, r);
      chk("t6_ctrl_reset", 64'(r), 64'd3);

      // ---- randomized traffic ----
      for (int t = 0; t < 300; t++) begin
         logic [2:0]  a;
         logic        w;
         logic [31:0] d;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         a = 3'($urandom_range(0, 7));
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         if (a == 3'd5) d = d & 32'h3;
         if (a == 3'd1 || a == 3'd3) d = d & 32'h3;
         bus(a, w, d, 4'($urandom_range(0, 15)), r, ac, lat);
      end

      repeat (4) @(negedge clk);
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
